// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexed driver for a 4-digit active-low
// 7-segment display. One digit is lit per slot, and each slot starts with a
// blanking gap to stop ghosting. New values are double-buffered and only
// reach the display at a frame boundary.
module seven_seg_scanner #(
   parameter int SCAN_CYCLES  = 100000,
   parameter int BLANK_CYCLES = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] value,
   input  logic [3:0]  dp,
   input  logic        load,
   input  logic        lz_blank,
   output logic [7:0]  seg,
   output logic [3:0]  sel,
   output logic        frame_done
);

   localparam int CW = $clog2(SCAN_CYCLES);
   localparam logic [CW-1:0] LAST_L  = CW'(SCAN_CYCLES - 1);
   localparam logic [CW-1:0] BLANK_L = CW'(BLANK_CYCLES);

   // Active-high a..g pattern for one hex nibble
   function automatic logic [6:0] hexfont(input logic [3:0] nib);
      logic [6:0] pat;
      case (nib)
         4'h0:    pat = 7'h3F;
         4'h1:    pat = 7'h06;
         4'h2:    pat = 7'h5B;
         4'h3:    pat = 7'h4F;
         4'h4:    pat = 7'h66;
         4'h5:    pat = 7'h6D;
         4'h6:    pat = 7'h7D;
         4'h7:    pat = 7'h07;
         4'h8:    pat = 7'h7F;
         4'h9:    pat = 7'h6F;
         4'hA:    pat = 7'h77;
         4'hB:    pat = 7'h7C;
         4'hC:    pat = 7'h39;
         4'hD:    pat = 7'h5E;
         4'hE:    pat = 7'h79;
         4'hF:    pat = 7'h71;
         default: pat = 7'h00;
      endcase
      return pat;
   endfunction

   logic [CW-1:0] cnt_r;
   logic [1:0]    dig_r;
   logic [15:0]   act_val_r;
   logic [3:0]    act_dp_r;
   logic [15:0]   pend_val_r;
   logic [3:0]    pend_dp_r;
   logic          pend_valid_r;

   logic          last_cnt_s;
   logic          boundary_s;
   logic          blank_s;
   logic [3:0]    cur_nib_s;
   logic          lead_zero_s;
   logic [7:0]    seg_nxt_s;
   logic [3:0]    sel_nxt_s;

   // Slot/phase decode and the next value of the display outputs
   always_comb begin
      last_cnt_s  = (cnt_r == LAST_L);
      boundary_s  = last_cnt_s && (dig_r == 2'd3);
      blank_s     = (cnt_r < BLANK_L);
      cur_nib_s   = 4'h0;
      lead_zero_s = 1'b0;
      case (dig_r)
         2'd0: begin
            cur_nib_s   = act_val_r[3:0];
            lead_zero_s = 1'b0;              // rightmost digit always shown
         end
         2'd1: begin
            cur_nib_s   = act_val_r[7:4];
            lead_zero_s = (act_val_r[15:4] == 12'h000);
         end
         2'd2: begin
            cur_nib_s   = act_val_r[11:8];
            lead_zero_s = (act_val_r[15:8] == 8'h00);
         end
         2'd3: begin
            cur_nib_s   = act_val_r[15:12];
            lead_zero_s = (act_val_r[15:12] == 4'h0);
         end
         default: begin
            cur_nib_s   = 4'h0;
            lead_zero_s = 1'b0;
         end
      endcase
      if (blank_s) begin
         sel_nxt_s = 4'hF;
         seg_nxt_s = 8'hFF;
      end else begin
         sel_nxt_s = ~(4'b0001 << dig_r);
         if (lz_blank && lead_zero_s) begin
            seg_nxt_s = {~act_dp_r[dig_r], 7'h7F};
         end else begin
            seg_nxt_s = {~act_dp_r[dig_r], ~hexfont(cur_nib_s)};
         end
      end
   end

   // Slot counter and digit index
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r <= '0;
         dig_r <= 2'd0;
      end else if (last_cnt_s) begin
         cnt_r <= '0;
         dig_r <= dig_r + 2'd1;
      end else begin
         cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
      end
   end

   // Pending/active buffers; a load at the boundary bypasses the pending stage
   always_ff @(posedge clk) begin
      if (rst) begin
         act_val_r    <= 16'h0000;
         act_dp_r     <= 4'h0;
         pend_val_r   <= 16'h0000;
         pend_dp_r    <= 4'h0;
         pend_valid_r <= 1'b0;
      end else if (boundary_s) begin
         if (load) begin
            act_val_r <= value;
            act_dp_r  <= dp;
         end else if (pend_valid_r) begin
            act_val_r <= pend_val_r;
            act_dp_r  <= pend_dp_r;
         end else begin
            act_val_r <= act_val_r;
            act_dp_r  <= act_dp_r;
         end
         pend_valid_r <= 1'b0;
      end else if (load) begin
         pend_val_r   <= value;
         pend_dp_r    <= dp;
         pend_valid_r <= 1'b1;
      end else begin
         pend_valid_r <= pend_valid_r;
      end
   end

   // Registered display outputs and frame pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         seg        <= 8'hFF;
         sel        <= 4'hF;
         frame_done <= 1'b0;
      end else begin
         seg        <= seg_nxt_s;
         sel        <= sel_nxt_s;
         frame_done <= boundary_s;
      end
   end

endmodule
